// File: rtl/sync_pulse_pkg.sv
// Shared definitions for the toggle-based pulse crossing (source side).
//   state_e          : source FSM states
//   SYNC_STAGES_MIN/MAX : legal depth range of the ack synchronizer
//   CNT_W_DEF        : default width of the pending-request counter
//   sync_stages_ok() : range check used at elaboration time
package sync_pulse_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int CNT_W_DEF       = 4;

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/sync_pulse_src_if.sv
// Request/toggle bundle between a requester and the source-side crossing stage.
//   sEN      : request pulse, one request per high cycle
//   sRDY     : pending counter not full
//   sTOG     : registered toggle level towards the destination synchronizer
//   sACK_TOG : toggle echoed back from the destination (asynchronous)
//   sBUSY    : crossing in flight
//   sPEND    : pending-request count
//   sOVF     : sticky overflow (request dropped while full)
// master = requester/destination side, slave = sync_pulse_src.
interface sync_pulse_src_if
    import sync_pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             sEN;
    logic             sRDY;
    logic             sTOG;
    logic             sACK_TOG;
    logic             sBUSY;
    logic [CNT_W-1:0] sPEND;
    logic             sOVF;

    modport master (
        output sEN,
        output sACK_TOG,
        input  sRDY,
        input  sTOG,
        input  sBUSY,
        input  sPEND,
        input  sOVF
    );

    modport slave (
        input  sEN,
        input  sACK_TOG,
        output sRDY,
        output sTOG,
        output sBUSY,
        output sPEND,
        output sOVF
    );
endinterface

// File: rtl/sync_ff_chain.sv
// N-flop synchronizer clocked by sCLK with synchronous reset to init.
//   sCLK : clock
//   sRST : synchronous active-high reset, loads every flop with init
//   d    : asynchronous input
//   q    : synchronized output (last flop of the chain)
module sync_ff_chain #(
    parameter int   N    = 2,
    parameter logic init = 1'b0
) (
    input  logic sCLK,
    input  logic sRST,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge sCLK) begin
        if (sRST) begin
            stages <= {N{init}};
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/sync_pulse_src.sv
// Source side of a toggle-based pulse crossing.
// Request pulses on sEN are turned into flips of the registered level sTOG.
// Only one flip is outstanding at a time: the next launch waits until the
// destination's echo (sACK_TOG, synchronized into sCLK) equals sTOG again.
// Requests arriving meanwhile are counted in a saturating pending counter.
//   sCLK : source clock
//   sRST : synchronous active-high reset
//   bus  : request/toggle bundle (slave side)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no flip outstanding; launches on a request
// WAIT_ACK | sTOG flipped, waiting for echo to match sTOG
module sync_pulse_src
    import sync_pulse_pkg::*;
#(
    parameter logic init        = 1'b0,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter int   SYNC_STAGES = 2
) (
    input  logic               sCLK,
    input  logic               sRST,
    sync_pulse_src_if.slave    bus
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_pulse_src: SYNC_STAGES out of range");
    end

    localparam logic [CNT_W-1:0] PEND_FULL = '1;
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

    state_e           state;
    logic             tog_q;
    logic [CNT_W-1:0] pend_q;
    logic             ovf_q;
    logic             ack_s;
    logic             full;
    logic             accept;
    logic             launch;

    sync_ff_chain #(
        .N    (SYNC_STAGES),
        .init (init)
    ) u_ack_sync (
        .sCLK (sCLK),
        .sRST (sRST),
        .d    (bus.sACK_TOG),
        .q    (ack_s)
    );

    assign full   = (pend_q == PEND_FULL);
    assign accept = bus.sEN && !full;
    // A request in IDLE with nothing queued launches directly, so a
    // simultaneous accept and launch leave the counter unchanged.
    assign launch = (state == IDLE) && ((pend_q != '0) || accept);

    always_ff @(posedge sCLK) begin
        if (sRST) begin
            state  <= IDLE;
            tog_q  <= init;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        tog_q <= ~tog_q;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Parity compare rather than edge detect: only whether the
                    // echo has caught up with the current level matters.
                    if (ack_s == tog_q) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            unique case ({accept, launch})
                2'b10:   pend_q <= pend_q + PEND_ONE;
                2'b01:   pend_q <= pend_q - PEND_ONE;
                default: pend_q <= pend_q;
            endcase

            if (bus.sEN && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.sRDY  = !full;
    assign bus.sTOG  = tog_q;
    assign bus.sBUSY = (state == WAIT_ACK);
    assign bus.sPEND = pend_q;
    assign bus.sOVF  = ovf_q;

endmodule

// File: tb/tb_sync_pulse_src.sv
module tb_sync_pulse_src;

    localparam logic INIT  = 1'b0;
    localparam int   CNT_W = 4;
    localparam int   SS    = 2;
    localparam int   PMAX  = (1 << CNT_W) - 1;

    logic sCLK;
    logic sRST;

    sync_pulse_src_if #(.CNT_W(CNT_W)) bus ();

    sync_pulse_src #(
        .init        (INIT),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SS)
    ) dut (
        .sCLK (sCLK),
        .sRST (sRST),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        sCLK = 1'b0;
        forever #5 sCLK = ~sCLK;
    end

    // Behavioural model: pending count, number of launches (toggle parity),
    // in-flight flag, and the ack value as seen SS samples ago.
    int  m_pend     = 0;
    int  m_launches = 0;
    bit  m_busy     = 0;
    bit  m_ovf      = 0;
    bit  m_valid    = 0;
    bit  hist [SS];

    initial begin
        forever begin
            @(posedge sCLK);
            if (sRST) begin
                m_pend     = 0;
                m_launches = 0;
                m_busy     = 0;
                m_ovf      = 0;
                for (int i = 0; i < SS; i++) hist[i] = INIT;
                m_valid    = 1;
            end else begin
                bit full_now, acc, lch, seen_ack, cur_tog;
                full_now = (m_pend == PMAX);
                acc      = bus.sEN && !full_now;
                if (bus.sEN && full_now) m_ovf = 1;
                seen_ack = hist[SS-1];
                cur_tog  = INIT ^ m_launches[0];
                lch      = 0;
                if (m_busy) begin
                    if (seen_ack == cur_tog) m_busy = 0;
                end else begin
                    lch = (m_pend > 0) || acc;
                end
                if (lch) begin
                    m_launches++;
                    m_busy = 1;
                end
                m_pend = m_pend + int'(acc) - int'(lch);
                for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = bus.sACK_TOG;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sCLK);
            if (m_valid) begin
                chk("cmp_tog",  int'(bus.sTOG),  int'(INIT ^ m_launches[0]));
                chk("cmp_busy", int'(bus.sBUSY), int'(m_busy));
                chk("cmp_pend", int'(bus.sPEND), m_pend);
                chk("cmp_rdy",  int'(bus.sRDY),  int'(m_pend != PMAX));
                chk("cmp_ovf",  int'(bus.sOVF),  int'(m_ovf));
            end
        end
    end

    int   flips;
    int   max_pend;
    logic prev_tog;

    task automatic cyc();
        @(posedge sCLK);
        #1;
        if (bus.sTOG !== prev_tog) flips++;
        prev_tog = bus.sTOG;
        if (int'(bus.sPEND) > max_pend) max_pend = int'(bus.sPEND);
    endtask

    task automatic do_reset();
        sRST         = 1'b1;
        bus.sEN      = 1'b0;
        bus.sACK_TOG = INIT;
        cyc();
        sRST     = 1'b0;
        flips    = 0;
        max_pend = 0;
        prev_tog = bus.sTOG;
    endtask

    // Destination stand-in: echoes sTOG straight back until everything retires.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bus.sBUSY || bus.sPEND != '0) && n < 400) begin
            bus.sACK_TOG = bus.sTOG;
            cyc();
            n++;
        end
        chk(name, int'(n < 400), 1);
    endtask

    task automatic ack_latency(input string name);
        int n;
        n = 0;
        while (bus.sBUSY && n < 20) begin
            cyc();
            n++;
        end
        chk(name, n, SS + 1);
    endtask

    initial begin
        flips    = 0;
        max_pend = 0;
        prev_tog = INIT;
        sRST         = 1'b1;
        bus.sEN      = 1'b0;
        bus.sACK_TOG = INIT;
        cyc();
        cyc();
        sRST     = 1'b0;
        prev_tog = bus.sTOG;
        chk("rst_rdy",  int'(bus.sRDY),  1);
        chk("rst_busy", int'(bus.sBUSY), 0);
        chk("rst_pend", int'(bus.sPEND), 0);
        chk("rst_ovf",  int'(bus.sOVF),  0);
        chk("rst_tog",  int'(bus.sTOG),  int'(INIT));

        // single request, echo after 5 cycles
        cyc();
        cyc();
        bus.sEN = 1'b1;
        cyc();
        bus.sEN = 1'b0;
        chk("t1_tog",  int'(bus.sTOG),  1);
        chk("t1_busy", int'(bus.sBUSY), 1);
        chk("t1_pend", int'(bus.sPEND), 0);
        repeat (5) cyc();
        chk("t1_still_busy", int'(bus.sBUSY), 1);
        bus.sACK_TOG = 1'b1;
        ack_latency("t1_ack_latency");
        chk("t1_max_pend", max_pend, 0);

        // burst of 4 while the first is in flight
        do_reset();
        bus.sEN = 1'b1;
        repeat (4) cyc();
        bus.sEN = 1'b0;
        chk("t2_pend", int'(bus.sPEND), 3);
        drain("t2_drain_timeout");
        chk("t2_flips",    flips, 4);
        chk("t2_tog_end",  int'(bus.sTOG), int'(INIT));
        chk("t2_max_pend", max_pend, 3);

        // saturation and sticky overflow
        do_reset();
        bus.sEN = 1'b1;
        repeat (16) cyc();
        chk("t3_pend_full", int'(bus.sPEND), 15);
        chk("t3_rdy_full",  int'(bus.sRDY),  0);
        chk("t3_ovf_pre",   int'(bus.sOVF),  0);
        cyc();
        bus.sEN = 1'b0;
        chk("t3_ovf_set",   int'(bus.sOVF),  1);
        chk("t3_pend_sat",  int'(bus.sPEND), 15);
        drain("t3_drain_timeout");
        chk("t3_ovf_sticky", int'(bus.sOVF), 1);
        chk("t3_flips",      flips, 16);
        chk("t3_tog_end",    int'(bus.sTOG), int'(INIT));

        // request on the first IDLE cycle with two queued
        do_reset();
        bus.sEN = 1'b1;
        repeat (3) cyc();
        bus.sEN = 1'b0;
        chk("t4_pend", int'(bus.sPEND), 2);
        bus.sACK_TOG = 1'b1;
        repeat (SS + 1) cyc();
        chk("t4_idle_busy", int'(bus.sBUSY), 0);
        chk("t4_idle_pend", int'(bus.sPEND), 2);
        bus.sEN = 1'b1;
        cyc();
        bus.sEN = 1'b0;
        chk("t4_launch_busy", int'(bus.sBUSY), 1);
        chk("t4_launch_pend", int'(bus.sPEND), 2);
        chk("t4_flips",       flips, 2);

        // reset in flight with 5 queued; sEN during reset ignored
        do_reset();
        bus.sEN = 1'b1;
        repeat (6) cyc();
        chk("t5_pend_pre", int'(bus.sPEND), 5);
        chk("t5_busy_pre", int'(bus.sBUSY), 1);
        sRST = 1'b1;
        cyc();
        sRST    = 1'b0;
        bus.sEN = 1'b0;
        chk("t5_tog",  int'(bus.sTOG),  int'(INIT));
        chk("t5_pend", int'(bus.sPEND), 0);
        chk("t5_busy", int'(bus.sBUSY), 0);
        chk("t5_ovf",  int'(bus.sOVF),  0);
        chk("t5_rdy",  int'(bus.sRDY),  1);
        cyc();
        chk("t5_quiet_busy", int'(bus.sBUSY), 0);
        bus.sEN = 1'b1;
        cyc();
        bus.sEN = 1'b0;
        chk("t5_fresh_tog",  int'(bus.sTOG),  1);
        chk("t5_fresh_busy", int'(bus.sBUSY), 1);
        chk("t5_fresh_pend", int'(bus.sPEND), 0);

        // sub-sample glitch on the echo must not end the wait
        #2 bus.sACK_TOG = 1'b1;
        #1 bus.sACK_TOG = 1'b0;
        repeat (6) cyc();
        chk("t6_glitch_busy", int'(bus.sBUSY), 1);
        bus.sACK_TOG = 1'b1;
        ack_latency("t6_ack_latency");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
